wb_ccff_loader: RTL and testbench
=================================

# wb_ccff_loader

Wishbone slave that streams 32-bit configuration words from the Caravel management SoC into the FPGA configuration chain. It sits directly upstream of `fpga_core`: it drives `prog_clk` and `ccff_head`, and samples `ccff_tail` back into a readable register. Each word is shifted LSB first with a generated two-phase programming clock. A one-word holding buffer plus Wishbone wait-states provide flow control, so software can stream a bitstream with plain writes.

## Interface
- `BASE_ADDR`, 32'h3000_0000: Wishbone base address. Decode compares `wbs_adr_i[31:4]` against `BASE_ADDR[31:4]`.
- `CNT_W`, 16: width of the total-bits-shifted counter.
- `wb_clk_i`  in  1  sole clock; all state in this domain.
- `wb_rst_n`  in  1  reset, asynchronous assert, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data; valid only while `wbs_ack_o`=1, 0 otherwise.
- `prog_clk`  out  1  configuration-chain clock (registered).
- `ccff_head`  out  1  configuration-chain serial data in (registered).
- `ccff_tail`  in  1  configuration-chain serial data out.
- `busy`  out  1  shift in progress; routed to the logic analyzer.

## Operation
- Register map, indexed by `wbs_adr_i[3:2]`:
  - 0 CTRL (R/W): bit0 `en`; bit1 `cnt_clr`, write-1, self-clearing, reads 0.
  - 1 STATUS (RO): bit0 `busy`; bit1 `pend_valid`; [31:16] `total_bits`.
  - 2 DATA (WO): pushes a word into the pending buffer. Reads return 0.
  - 3 TAIL (RO): the last 32 `ccff_tail` samples, newest bit in [31].
- CTRL writes take effect only when `wbs_sel_i[0]`=1. DATA writes with `wbs_sel_i`≠4'hF are acked but ignored. Writes to STATUS and TAIL are acked with no effect.
- Accesses whose address falls outside the decoded base are never acked.
- Pending buffer: one entry, `pend_data` plus `pend_valid`. A DATA write while `pend_valid`=1 is stalled: ack is withheld until the engine consumes the pending word, and the new word is stored in that same cycle.
- FSM states are IDLE, SETUP and PULSE.
  - IDLE: when `en`=1 and `pend_valid`=1: `shreg`←`pend_data`, clear `pend_valid`, `bit_idx`←0, go to SETUP.
  - SETUP: `ccff_head`←`shreg[0]`, `prog_clk`←0, go to PULSE.
  - PULSE: `prog_clk`←1; `tail`←{`ccff_tail`,`tail[31:1]`}; `shreg`>>=1; `bit_idx`++; `total_bits`++.
  - PULSE exit when `bit_idx`=31: if `en`=1 and `pend_valid`=1, load the next word and go to SETUP (gapless); otherwise go to IDLE.
  - PULSE exit when `bit_idx`≠31: go to SETUP.
- `busy`=1 in SETUP and PULSE.
- Clearing `en` mid-word: the current word completes, then the FSM stops in IDLE. A pending word is retained.
- `total_bits` wraps at 2^CNT_W−1 → 0. When `cnt_clr` and an increment occur in the same cycle, clear wins and the result is 0.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `prog_clk`=0, `ccff_head`=0, `busy`=0. All internal registers are 0, FSM is in IDLE.
- Ack timing:
  - Non-stalled access: ack asserts the cycle after `stb&cyc` is sampled, lasts one cycle, and is never asserted on two consecutive cycles.
  - Stalled DATA write: ack asserts the cycle after `pend_valid` is cleared.
- Shift timing:
  - Each bit takes 2 cycles, so a word takes 64 cycles from SETUP entry to the last PULSE.
  - The first SETUP occurs 1 cycle after the DATA-write ack when the FSM is idle with `en`=1.
  - `prog_clk` period is 2 cycles at 50% duty. `ccff_head` is stable one full cycle before each `prog_clk` rise.
  - `ccff_tail` is sampled on the cycle `prog_clk` goes high. The chain captures on the `prog_clk` rising edge, so the tail value is settled by then.
- Reset mid-shift: `prog_clk` and `ccff_head` drop to 0 immediately (asynchronous). Any partial word is lost.

## Structure
- Package `caravel_fpga_pkg` holds:
  - register index constants (`REG_CTRL`, `REG_STATUS`, `REG_DATA`, `REG_TAIL`);
  - the FSM state typedef;
  - `CCFF_WORD_W` = 32.
- Sub-module `ccff_shift_engine` holds the FSM, `shreg`, `bit_idx`, tail capture and the `prog_clk`/`ccff_head` registers. The top level holds the Wishbone decode, CTRL, the pending buffer and the counter.

## Test plan
- Reset, then read STATUS and TAIL → both read 0; `prog_clk` and `ccff_head` are 0 throughout.
- Set CTRL `en`=1, write DATA 32'hA5A5_0F0F → exactly 32 `prog_clk` rises. `ccff_head` at each rise follows 1,1,1,1,0,0,0,0,… (LSB first). STATUS then reads `total_bits`=32, `busy`=0.
- Loop `ccff_tail` to a model 32-bit shift register preloaded with 32'hDEAD_BEEF, shift one word → TAIL reads 32'hDEAD_BEEF.
- With `en`=1, write three DATA words back-to-back → the third write's ack is delayed until the first word finishes. `prog_clk` toggles with no gap across 96 bits; STATUS reads `total_bits`=96.
- Write DATA with `en`=0 → no `prog_clk` activity, STATUS reads `pend_valid`=1. Then set `en`=1 → shifting starts within 2 cycles. Clear `en` at bit 10 → the word still completes to 32 bits.
- Preload `total_bits`=16'hFFFF, then write `cnt_clr` in the same cycle as a PULSE → counter reads 0. Also assert `wb_rst_n`=0 mid-word → outputs go to 0 asynchronously.

Source files
------------

// File: rtl/caravel_fpga_pkg.sv
// Shared constants and types for the Wishbone-to-configuration-chain loader.
package caravel_fpga_pkg;

  localparam int CCFF_WORD_W = 32;
  localparam int BIT_IDX_W   = $clog2(CCFF_WORD_W);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_TAIL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2
  } ccff_state_e;

endpackage

// File: rtl/ccff_shift_engine.sv
// Serialises one word LSB first onto the configuration chain with a two-phase
// programming clock, capturing the chain's tail output on every rising edge.
module ccff_shift_engine
  import caravel_fpga_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_pend_valid,
  input  logic [CCFF_WORD_W-1:0] i_pend_data,
  input  logic                   i_ccff_tail,
  output logic                   o_take,
  output logic                   o_pulse,
  output logic                   o_prog_clk,
  output logic                   o_ccff_head,
  output logic                   o_busy,
  output logic [CCFF_WORD_W-1:0] o_tail
);

  ccff_state_e            r_state;
  logic [CCFF_WORD_W-1:0] r_shreg;
  logic [CCFF_WORD_W-1:0] r_tail;
  logic [BIT_IDX_W-1:0]   r_bit_idx;
  logic                   r_prog_clk;
  logic                   r_head;
  logic                   r_busy;
  logic                   w_last;
  logic                   w_take;

  assign w_last = (r_bit_idx == BIT_IDX_W'(CCFF_WORD_W - 1));
  // A word is pulled from the holding buffer either from idle or straight off
  // the final pulse of the previous word, which keeps back-to-back words gapless.
  assign w_take = i_en & i_pend_valid &
                  ((r_state == ST_IDLE) | ((r_state == ST_PULSE) & w_last));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_tail     <= '0;
      r_bit_idx  <= '0;
      r_prog_clk <= 1'b0;
      r_head     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_prog_clk <= 1'b0;
          if (w_take) begin
            r_shreg   <= i_pend_data;
            r_bit_idx <= '0;
            r_state   <= ST_SETUP;
            r_busy    <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_head     <= r_shreg[0];
          r_prog_clk <= 1'b0;
          r_state    <= ST_PULSE;
        end
        ST_PULSE: begin
          r_prog_clk <= 1'b1;
          r_tail     <= {i_ccff_tail, r_tail[CCFF_WORD_W-1:1]};
          r_shreg    <= r_shreg >> 1;
          r_bit_idx  <= r_bit_idx + BIT_IDX_W'(1);
          if (!w_last) begin
            r_state <= ST_SETUP;
          end else if (w_take) begin
            r_shreg   <= i_pend_data;
            r_bit_idx <= '0;
            r_state   <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_take      = w_take;
  assign o_pulse     = (r_state == ST_PULSE);
  assign o_prog_clk  = r_prog_clk;
  assign o_ccff_head = r_head;
  assign o_busy      = r_busy;
  assign o_tail      = r_tail;

endmodule

// File: rtl/wb_ccff_loader.sv
// Wishbone slave that buffers one configuration word and hands it to the
// shift engine; holds CTRL, the pending buffer and the shifted-bit counter.
module wb_ccff_loader
  import caravel_fpga_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk,
  output logic        ccff_head,
  input  logic        ccff_tail,
  output logic        busy
);

  logic                   r_ack;
  logic [31:0]            r_dat;
  logic                   r_en;
  logic                   r_pend_valid;
  logic [CCFF_WORD_W-1:0] r_pend_data;
  logic [CNT_W-1:0]       r_total_bits;

  logic                   w_hit;
  logic [1:0]             w_idx;
  logic                   w_data_wr;
  logic                   w_stall;
  logic                   w_acc;
  logic                   w_ctrl_wr;
  logic                   w_cnt_clr;
  logic                   w_take;
  logic                   w_pulse;
  logic                   w_busy;
  logic [CCFF_WORD_W-1:0] w_tail;
  logic [31:0]            w_rdata;
  logic                   w_unused;

  assign w_idx     = wbs_adr_i[3:2];
  // Gating on r_ack spaces acks apart so a held strobe is never acked twice in a row.
  assign w_hit     = wbs_stb_i & wbs_cyc_i & ~r_ack &
                     (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_data_wr = w_hit & wbs_we_i & (w_idx == REG_DATA) & (wbs_sel_i == 4'hF);
  assign w_stall   = w_data_wr & r_pend_valid & ~w_take;
  assign w_acc     = w_hit & ~w_stall;
  assign w_ctrl_wr = w_acc & wbs_we_i & (w_idx == REG_CTRL) & wbs_sel_i[0];
  assign w_cnt_clr = w_ctrl_wr & wbs_dat_i[1];
  assign w_unused  = ^wbs_adr_i[1:0];

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL:   w_rdata = {31'd0, r_en};
      REG_STATUS: w_rdata = {16'(r_total_bits), 14'd0, r_pend_valid, w_busy};
      REG_TAIL:   w_rdata = w_tail;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_en         <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_total_bits <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc & ~wbs_we_i) ? w_rdata : 32'd0;
      if (w_ctrl_wr) begin
        r_en <= wbs_dat_i[0];
      end
      // A stalled write lands in the same cycle the engine drains the buffer.
      if (w_acc & w_data_wr) begin
        r_pend_data  <= wbs_dat_i;
        r_pend_valid <= 1'b1;
      end else if (w_take) begin
        r_pend_valid <= 1'b0;
      end
      if (w_cnt_clr) begin
        r_total_bits <= '0;
      end else if (w_pulse) begin
        r_total_bits <= r_total_bits + CNT_W'(1);
      end
    end
  end

  ccff_shift_engine u_engine (
    .i_clk        (wb_clk_i),
    .i_rst_n      (wb_rst_n),
    .i_en         (r_en),
    .i_pend_valid (r_pend_valid),
    .i_pend_data  (r_pend_data),
    .i_ccff_tail  (ccff_tail),
    .o_take       (w_take),
    .o_pulse      (w_pulse),
    .o_prog_clk   (prog_clk),
    .o_ccff_head  (ccff_head),
    .o_busy       (w_busy),
    .o_tail       (w_tail)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign busy      = w_busy;

endmodule

// File: tb/tb_wb_ccff_loader.sv
// Self-checking bench: random configuration words against a queue-based model
// of the bit stream and a behavioural 32-bit configuration chain.
module tb_wb_ccff_loader;
  import caravel_fpga_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        prog_clk;
  logic        ccff_head;
  logic        ccff_tail;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit bus_ok = 1'b1;

  wb_ccff_loader #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_n  (wb_rst_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .prog_clk  (prog_clk),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .busy      (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // Behavioural configuration chain plus a record of every programming-clock rise.
  logic [31:0] chain = '0;
  int rises = 0;
  bit rx_q[$];
  int rise_cyc[$];
  assign ccff_tail = chain[0];
  always @(posedge prog_clk) begin
    rises = rises + 1;
    rx_q.push_back(ccff_head);
    rise_cyc.push_back(cyc_cnt);
    chain <= {ccff_head, chain[31:1]};
  end

  function automatic logic [31:0] rx_word(input int w);
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++)
      if (w * 32 + i < rx_q.size()) v[i] = rx_q[w * 32 + i];
    return v;
  endfunction

  task automatic clear_monitor();
    rises = 0;
    rx_q.delete();
    rise_cyc.delete();
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int max_cyc,
                         output logic [31:0] rdata, output bit acked, output int waited);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    acked = 1'b0; waited = 0; rdata = '0;
    while (!acked && waited < max_cyc) begin
      @(posedge wb_clk_i); #1; waited++;
      if (wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        rdata = wbs_dat_o;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] dat);
    logic [31:0] rd; bit ok; int w;
    wb_xfer(1'b1, BASE | {28'd0, idx, 2'd0}, dat, 4'hF, 300, rd, ok, w);
    if (!ok) bus_ok = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] rd);
    bit ok; int w;
    wb_xfer(1'b0, BASE | {28'd0, idx, 2'd0}, 32'd0, 4'hF, 20, rd, ok, w);
    if (!ok) bus_ok = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int bound, output bit ok);
    int k = 0;
    while (rises < n && k < bound) begin
      @(posedge wb_clk_i); #1; k++;
    end
    ok = (rises >= n);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checks++; if (wbs_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", wbs_ack_o); end
    checks++; if (wbs_dat_o !== 32'd0) begin failures++; $display("FAIL rst_dat got=%h exp=0", wbs_dat_o); end
    checks++; if (prog_clk !== 1'b0) begin failures++; $display("FAIL rst_prog_clk got=%b exp=0", prog_clk); end
    checks++; if (ccff_head !== 1'b0) begin failures++; $display("FAIL rst_head got=%b exp=0", ccff_head); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    wb_rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rst_status got=%h exp=0", rd); end
    wb_read(REG_TAIL, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rst_tail got=%h exp=0", rd); end
    checks++; if (rises !== 0) begin failures++; $display("FAIL rst_no_rises got=%0d exp=0", rises); end
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    logic [31:0] rd; bit ok;
    chain = 32'hDEAD_BEEF;
    wb_write(REG_CTRL, 32'h3);
    clear_monitor();
    wb_write(REG_DATA, 32'hA5A5_0F0F);
    wait_rises(32, 200, ok);
    repeat (6) @(posedge wb_clk_i);
    #1;
    checks++; if (rises !== 32) begin failures++; $display("FAIL single_rises got=%0d exp=32", rises); end
    checks++; if (rx_word(0) !== 32'hA5A5_0F0F) begin failures++; $display("FAIL single_head got=%h exp=a5a50f0f", rx_word(0)); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0020_0000) begin failures++; $display("FAIL single_status got=%h exp=00200000", rd); end
    wb_read(REG_TAIL, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_tail got=%h exp=deadbeef", rd); end
    wb_read(REG_CTRL, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL single_ctrl got=%h exp=1", rd); end
    $display("test_single_word word=a5a50f0f rises=%0d", rises);
  endtask

  task automatic test_random_words();
    logic [31:0] rd, w, prev; bit ok; int exp_total;
    prev = $urandom;
    chain = prev;
    wb_write(REG_CTRL, 32'h3);
    exp_total = 0;
    for (int it = 0; it < 4; it++) begin
      w = $urandom;
      clear_monitor();
      wb_write(REG_DATA, w);
      wait_rises(32, 200, ok);
      repeat (4) @(posedge wb_clk_i);
      #1;
      exp_total += 32;
      checks++; if (rises !== 32) begin failures++; $display("FAIL rand_rises got=%0d exp=32", rises); end
      checks++; if (rx_word(0) !== w) begin failures++; $display("FAIL rand_head got=%h exp=%h", rx_word(0), w); end
      wb_read(REG_TAIL, rd);
      checks++; if (rd !== prev) begin failures++; $display("FAIL rand_tail got=%h exp=%h", rd, prev); end
      wb_read(REG_STATUS, rd);
      checks++; if (rd !== {16'(exp_total), 16'd0}) begin failures++; $display("FAIL rand_status got=%h exp=%h", rd, {16'(exp_total), 16'd0}); end
      $display("test_random_words word=%h tail=%h", w, rd);
      prev = w;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [31:0] w [3]; bit ok, a0, a1, a2; int wt, r_at_ack3, bad;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    wb_write(REG_CTRL, 32'h3);
    clear_monitor();
    wb_xfer(1'b1, BASE | 32'h8, w[0], 4'hF, 300, rd, a0, wt);
    wb_xfer(1'b1, BASE | 32'h8, w[1], 4'hF, 300, rd, a1, wt);
    wb_xfer(1'b1, BASE | 32'h8, w[2], 4'hF, 300, rd, a2, wt);
    r_at_ack3 = rises;
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL b2b_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if (r_at_ack3 !== 32) begin failures++; $display("FAIL b2b_ack3_timing got=%0d rises exp=32", r_at_ack3); end
    checks++; if (wt <= 8) begin failures++; $display("FAIL b2b_ack3_stall got=%0d cycles exp>8", wt); end
    wait_rises(96, 400, ok);
    repeat (6) @(posedge wb_clk_i);
    #1;
    checks++; if (rises !== 96) begin failures++; $display("FAIL b2b_rises got=%0d exp=96", rises); end
    bad = 0;
    for (int i = 1; i < rise_cyc.size(); i++)
      if (rise_cyc[i] - rise_cyc[i-1] != 2) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_gapless got=%0d bad gaps exp=0", bad); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx_word(i) !== w[i]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, rx_word(i), w[i]); end
    end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0060_0000) begin failures++; $display("FAIL b2b_status got=%h exp=00600000", rd); end
    $display("test_back_to_back words=%h,%h,%h ack3_wait=%0d", w[0], w[1], w[2], wt);
  endtask

  task automatic test_enable_gate();
    logic [31:0] rd, w1, w2; bit ok; int k;
    w1 = $urandom; w2 = $urandom;
    wb_write(REG_CTRL, 32'h2);
    clear_monitor();
    wb_write(REG_DATA, w1);
    repeat (10) @(posedge wb_clk_i);
    #1;
    checks++; if (rises !== 0) begin failures++; $display("FAIL gate_idle_rises got=%0d exp=0", rises); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0000_0002) begin failures++; $display("FAIL gate_pend_status got=%h exp=00000002", rd); end
    wb_write(REG_CTRL, 32'h1);
    k = 0;
    while (busy !== 1'b1 && k < 2) begin @(posedge wb_clk_i); #1; k++; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gate_start got=%b exp=1 within 2 cycles", busy); end
    wb_write(REG_DATA, w2);
    wait_rises(10, 100, ok);
    wb_write(REG_CTRL, 32'h0);
    wait_rises(32, 200, ok);
    repeat (80) @(posedge wb_clk_i);
    #1;
    checks++; if (rises !== 32) begin failures++; $display("FAIL gate_complete got=%0d exp=32", rises); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0020_0002) begin failures++; $display("FAIL gate_retained got=%h exp=00200002", rd); end
    wb_write(REG_CTRL, 32'h1);
    wait_rises(64, 200, ok);
    repeat (4) @(posedge wb_clk_i);
    #1;
    checks++; if ({rx_word(1), rx_word(0)} !== {w2, w1}) begin failures++; $display("FAIL gate_words got=%h%h exp=%h%h", rx_word(1), rx_word(0), w2, w1); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0040_0000) begin failures++; $display("FAIL gate_final_status got=%h exp=00400000", rd); end
    $display("test_enable_gate words=%h,%h rises=%0d", w1, w2, rises);
  endtask

  task automatic test_cnt_clr_pulse();
    logic [31:0] rd; bit ok;
    wb_write(REG_CTRL, 32'h3);
    clear_monitor();
    wb_write(REG_DATA, $urandom);
    wait_rises(31, 200, ok);
    @(posedge wb_clk_i); #1;
    wb_write(REG_CTRL, 32'h3);
    repeat (6) @(posedge wb_clk_i);
    #1;
    checks++; if (rises !== 32) begin failures++; $display("FAIL clr_rises got=%0d exp=32", rises); end
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0000_0000) begin failures++; $display("FAIL clr_wins got=%h exp=00000000", rd); end
    $display("test_cnt_clr_pulse status=%h", rd);
  endtask

  task automatic test_decode_and_sel();
    logic [31:0] rd; bit ok; int wt, acks, pairs; logic prev_ack;
    wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, 8, rd, ok, wt);
    checks++; if (ok !== 1'b0) begin failures++; $display("FAIL decode_near got=%b exp=0", ok); end
    wb_xfer(1'b1, 32'h4000_0008, 32'h1234_5678, 4'hF, 8, rd, ok, wt);
    checks++; if (ok !== 1'b0) begin failures++; $display("FAIL decode_far got=%b exp=0", ok); end
    wb_xfer(1'b1, BASE, 32'h0, 4'hE, 20, rd, ok, wt);
    wb_read(REG_CTRL, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL sel_ctrl got=%h exp=1", rd); end
    clear_monitor();
    wb_xfer(1'b1, BASE | 32'h8, $urandom, 4'h7, 20, rd, ok, wt);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sel_data_ack got=%b exp=1", ok); end
    wb_write(REG_STATUS, 32'hFFFF_FFFF);
    repeat (6) @(posedge wb_clk_i);
    #1;
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0000_0000) begin failures++; $display("FAIL sel_data_ignored got=%h exp=00000000", rd); end
    wb_read(REG_DATA, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL data_read got=%h exp=0", rd); end
    // Hold the strobe for six cycles: acks must alternate, never back to back.
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE; wbs_sel_i = 4'hF;
    acks = 0; pairs = 0; prev_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o === 1'b1) acks++;
      if (wbs_ack_o === 1'b1 && prev_ack === 1'b1) pairs++;
      prev_ack = wbs_ack_o;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(posedge wb_clk_i); #1;
    checks++; if (pairs !== 0 || acks !== 3) begin failures++; $display("FAIL ack_spacing got=%0d acks %0d pairs exp=3 acks 0 pairs", acks, pairs); end
    $display("test_decode_and_sel acks=%0d", acks);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit ok;
    wb_write(REG_CTRL, 32'h3);
    clear_monitor();
    wb_write(REG_DATA, 32'hFFFF_FFFF);
    wait_rises(5, 100, ok);
    checks++; if ({prog_clk, ccff_head} !== 2'b11) begin failures++; $display("FAIL mid_pre got=%b exp=11", {prog_clk, ccff_head}); end
    #3 wb_rst_n = 1'b0;
    #1;
    checks++; if ({prog_clk, ccff_head, busy} !== 3'b000) begin failures++; $display("FAIL mid_async got=%b exp=000", {prog_clk, ccff_head, busy}); end
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    clear_monitor();
    wb_read(REG_STATUS, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_status got=%h exp=0", rd); end
    wb_read(REG_CTRL, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_ctrl got=%h exp=0", rd); end
    repeat (10) @(posedge wb_clk_i);
    #1;
    checks++; if (rises !== 0) begin failures++; $display("FAIL mid_lost got=%0d exp=0", rises); end
    $display("test_reset_mid done");
  endtask

  task automatic test_bus_health();
    checks++; if (bus_ok !== 1'b1) begin failures++; $display("FAIL bus_timeout got=%b exp=1", bus_ok); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_random_words();
    test_back_to_back();
    test_enable_gate();
    test_cnt_clr_pulse();
    test_decode_and_sel();
    test_reset_mid();
    test_bus_health();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
